// File: rtl/motor_pkg.sv
// Shared encodings for the line-tracker steering bus, the H-bridge direction pins
// and the motor drive FSM.
package motor_pkg;

    localparam logic [1:0] ST_STOP     = 2'b00;
    localparam logic [1:0] ST_RIGHT    = 2'b01;
    localparam logic [1:0] ST_LEFT     = 2'b10;
    localparam logic [1:0] ST_STRAIGHT = 2'b11;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_COAST = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } motor_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One wheel: optional slew-limited duty ramp (MOTOR_RAMP_EN), period-end duty latch,
// and registered PWM/direction outputs driven from the shared period counter.
module pwm_channel
    import motor_pkg::*;
#(
    parameter int PWM_BITS = 10
`ifdef MOTOR_RAMP_EN
    ,
    parameter logic [PWM_BITS-1:0] RAMP_STEP = 10'd16
`endif
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clr_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                period_end_i,
`ifdef MOTOR_RAMP_EN
    input  logic                ramp_tick_i,
    output logic [PWM_BITS-1:0] cur_duty_o,
`endif
    input  logic [PWM_BITS-1:0] target_i,
    output logic [PWM_BITS-1:0] app_duty_o,
    output logic                pwm_o,
    output logic [1:0]          dir_o
);

    logic [PWM_BITS-1:0] cur_duty;
    logic [PWM_BITS-1:0] app_q, app_d;
    logic                pwm_q, pwm_d;
    logic [1:0]          dir_q, dir_d;

`ifdef MOTOR_RAMP_EN
    logic [PWM_BITS-1:0] cur_q, cur_d, gap, step;
    logic                up;

    // Step is clamped to the remaining gap so the duty lands exactly on target.
    always_comb begin
        up    = target_i > cur_q;
        gap   = up ? (target_i - cur_q) : (cur_q - target_i);
        step  = (gap < RAMP_STEP) ? gap : RAMP_STEP;
        cur_d = cur_q;
        if (clr_i)
            cur_d = '0;
        else if (ramp_tick_i)
            cur_d = up ? (cur_q + step) : (cur_q - step);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cur_q <= '0;
        else         cur_q <= cur_d;
    end

    assign cur_duty   = cur_q;
    assign cur_duty_o = cur_q;
`else
    assign cur_duty = target_i;
`endif

    // The latch samples the pre-update duty, so a same-cycle ramp step shows next period.
    always_comb begin
        app_d = app_q;
        pwm_d = 1'b0;
        dir_d = DIR_COAST;
        if (clr_i) begin
            app_d = '0;
        end else begin
            if (period_end_i) app_d = cur_duty;
            pwm_d = pwm_cnt_i < app_q;
            dir_d = (app_q != '0) ? DIR_FWD : DIR_COAST;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            app_q <= '0;
            pwm_q <= 1'b0;
            dir_q <= DIR_COAST;
        end else begin
            app_q <= app_d;
            pwm_q <= pwm_d;
            dir_q <= dir_d;
        end
    end

    assign app_duty_o = app_q;
    assign pwm_o      = pwm_q;
    assign dir_o      = dir_q;

endmodule

// File: rtl/motor_pwm_drive.sv
// Steering-state to dual-wheel PWM/H-bridge drive with start/stop FSM.
// Define MOTOR_RAMP_EN for slew-limited duty changes; otherwise duties step directly.
module motor_pwm_drive
    import motor_pkg::*;
#(
    parameter int                  PWM_BITS  = 10,
    parameter logic [PWM_BITS-1:0] DUTY_FAST = 10'd700,
    parameter logic [PWM_BITS-1:0] DUTY_SLOW = 10'd250,
    parameter int                  RAMP_DIV  = 4096,
    parameter logic [PWM_BITS-1:0] RAMP_STEP = 10'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       start_move,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic       moving
);

    motor_state_e        fsm_q, fsm_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] tgt_l_q, tgt_r_q, tgt_l_d, tgt_r_d;
    logic [PWM_BITS-1:0] app_l, app_r;
    logic                running, period_end, clr, done;

    assign running    = (fsm_q != S_IDLE);
    assign period_end = running && (pwm_cnt_q == '1);
    assign clr        = (fsm_d == S_IDLE);

`ifdef MOTOR_RAMP_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [RW-1:0]       ramp_cnt_q;
    logic                ramp_tick;
    logic [PWM_BITS-1:0] cur_l, cur_r;

    assign ramp_tick = running && (ramp_cnt_q == RW'(RAMP_DIV - 1));
    assign done      = (cur_l == '0) && (cur_r == '0);

    always_ff @(posedge clk) begin
        if (reset || clr)   ramp_cnt_q <= '0;
        else if (ramp_tick) ramp_cnt_q <= '0;
        else if (running)   ramp_cnt_q <= ramp_cnt_q + 1'b1;
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{RAMP_DIV, RAMP_STEP};
    assign done            = period_end;
`endif

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            S_IDLE:     if (start_move) fsm_d = S_RUN;
            S_RUN:      if (!start_move) fsm_d = S_STOPPING;
            S_STOPPING: begin
                if (start_move) fsm_d = S_RUN;
                else if (done)  fsm_d = S_IDLE;
            end
            default:    fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        tgt_l_d = '0;
        tgt_r_d = '0;
        if (fsm_q == S_RUN) begin
            case (state)
                ST_STRAIGHT: begin tgt_l_d = DUTY_FAST; tgt_r_d = DUTY_FAST; end
                ST_LEFT:     begin tgt_l_d = DUTY_SLOW; tgt_r_d = DUTY_FAST; end
                ST_RIGHT:    begin tgt_l_d = DUTY_FAST; tgt_r_d = DUTY_SLOW; end
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= S_IDLE;
            pwm_cnt_q <= '0;
            tgt_l_q   <= '0;
            tgt_r_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            pwm_cnt_q <= clr ? '0 : (running ? pwm_cnt_q + 1'b1 : pwm_cnt_q);
            tgt_l_q   <= tgt_l_d;
            tgt_r_q   <= tgt_r_d;
        end
    end

`ifdef MOTOR_RAMP_EN
    pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
        .clk_i(clk), .reset_i(reset), .clr_i(clr), .pwm_cnt_i(pwm_cnt_q),
        .period_end_i(period_end), .ramp_tick_i(ramp_tick), .cur_duty_o(cur_l),
        .target_i(tgt_l_q), .app_duty_o(app_l), .pwm_o(left_pwm), .dir_o(left_dir)
    );
    pwm_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
        .clk_i(clk), .reset_i(reset), .clr_i(clr), .pwm_cnt_i(pwm_cnt_q),
        .period_end_i(period_end), .ramp_tick_i(ramp_tick), .cur_duty_o(cur_r),
        .target_i(tgt_r_q), .app_duty_o(app_r), .pwm_o(right_pwm), .dir_o(right_dir)
    );
`else
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_left (
        .clk_i(clk), .reset_i(reset), .clr_i(clr), .pwm_cnt_i(pwm_cnt_q),
        .period_end_i(period_end), .target_i(tgt_l_q), .app_duty_o(app_l),
        .pwm_o(left_pwm), .dir_o(left_dir)
    );
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_right (
        .clk_i(clk), .reset_i(reset), .clr_i(clr), .pwm_cnt_i(pwm_cnt_q),
        .period_end_i(period_end), .target_i(tgt_r_q), .app_duty_o(app_r),
        .pwm_o(right_pwm), .dir_o(right_dir)
    );
`endif

    assign moving = (app_l != '0) || (app_r != '0);

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Randomized scoreboard bench: a period-level reference model predicts the high time,
// direction and moving flag of every PWM window; a monitor checks the DUT against it.
module tb_motor_pwm_drive;

    localparam int PB   = 5;
    localparam int N    = 32;
    localparam int DF   = 22;
    localparam int DS   = 8;
    localparam int RD   = 48;
    localparam int RS   = 3;
    localparam int MAXC = 32768;

    localparam int M_NONE = 0, M_IDLE = 1, M_RUN = 2, M_STOP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = 2'b00;
    logic       start_move = 1'b0;
    logic       left_pwm, right_pwm, moving;
    logic [1:0] left_dir, right_dir;

    motor_pwm_drive #(
        .PWM_BITS(PB), .DUTY_FAST(5'd22), .DUTY_SLOW(5'd8),
        .RAMP_DIV(RD), .RAMP_STEP(5'd3)
    ) dut (
        .clk(clk), .reset(reset), .state(state), .start_move(start_move),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        int first;
        int last;
        int hl;
        int hr;
        int nzl;
        int nzr;
    } win_t;

    win_t       q[$];
    logic [6:0] hist [0:MAXC-1];
    int         ecnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    // reference model state (plain integers)
    int mode = M_NONE;
    int t, tl, tr, cl, cr, al, ar;
    int w_first, w_al, w_ar;

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    task automatic check(input string name, input int act, input int exp, input int at);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s window@%0d: got %0d expected %0d", name, at, act, exp);
        end
    endtask

    function automatic void tmap(input logic [1:0] st, output int l, output int r);
        case (st)
            2'b11:   begin l = DF; r = DF; end
            2'b10:   begin l = DS; r = DF; end
            2'b01:   begin l = DF; r = DS; end
            default: begin l = 0;  r = 0;  end
        endcase
    endfunction

    function automatic int toward(input int c, input int tg);
        int d;
        d = (tg > c) ? tg - c : c - tg;
        if (d > RS) d = RS;
        return (tg > c) ? c + d : c - d;
    endfunction

    task automatic wopen(input int f, input int l, input int r);
        w_first = f; w_al = l; w_ar = r;
    endtask

    // A window of len samples at applied duty a shows min(a, len) high cycles.
    task automatic wclose(input int last);
        win_t w;
        int   len;
        len = last - w_first + 1;
        if (len > 0) begin
            w.first = w_first;
            w.last  = last;
            w.hl    = (w_al < len) ? w_al : len;
            w.hr    = (w_ar < len) ? w_ar : len;
            w.nzl   = int'(w_al != 0);
            w.nzr   = int'(w_ar != 0);
            q.push_back(w);
        end
    endtask

    task automatic clear_model();
        t = 0; tl = 0; tr = 0; cl = 0; cr = 0; al = 0; ar = 0;
    endtask

    // Predict the effect of the clock edge numbered e with the given inputs.
    task automatic model_edge(input bit rst, input bit sm, input logic [1:0] st, input int e);
        int  ntl, ntr, ocl, ocr, nmode;
        bit  latch, done;
        if (rst) begin
            if (mode == M_RUN || mode == M_STOP) begin wclose(e - 1); wopen(e, 0, 0); end
            else if (mode == M_NONE) wopen(e, 0, 0);
            mode = M_IDLE;
            clear_model();
        end else if (mode == M_IDLE) begin
            if (sm) begin
                wclose(e);
                wopen(e + 1, 0, 0);
                mode = M_RUN;
                clear_model();
            end
        end else if (mode == M_RUN || mode == M_STOP) begin
            t++;
            if (mode == M_RUN) tmap(st, ntl, ntr);
            else begin ntl = 0; ntr = 0; end
            latch = (t % N == 0);
`ifdef MOTOR_RAMP_EN
            ocl = cl; ocr = cr;
            if (t % RD == 0) begin cl = toward(cl, tl); cr = toward(cr, tr); end
            done = (ocl == 0 && ocr == 0);
`else
            ocl = tl; ocr = tr;
            cl = ntl; cr = ntr;
            done = latch;
`endif
            if (latch) begin al = ocl; ar = ocr; end
            if (sm)                 nmode = M_RUN;
            else if (mode == M_RUN) nmode = M_STOP;
            else                    nmode = done ? M_IDLE : M_STOP;
            if (nmode == M_IDLE) begin
                wclose(e - 1);
                wopen(e, 0, 0);
                clear_model();
            end else begin
                if (latch) begin wclose(e); wopen(e + 1, al, ar); end
                tl = ntl; tr = ntr;
            end
            mode = nmode;
        end
    endtask

    task automatic cyc(input bit r, input bit sm, input logic [1:0] st);
        reset = r; start_move = sm; state = st;
        model_edge(r, sm, st, ecnt + 1);
        @(negedge clk);
    endtask

    // Monitor: record every sample, evaluate each predicted window once fully observed.
    initial forever begin
        win_t       w;
        int         hl, hr, dbad;
        logic [1:0] edl, edr;
        @(negedge clk);
        if (ecnt < MAXC) hist[ecnt] = {moving, right_dir, left_dir, right_pwm, left_pwm};
        while (q.size() > 0 && q[0].last <= ecnt) begin
            w = q.pop_front();
            if (w.last < MAXC) begin
                hl = 0; hr = 0; dbad = 0;
                edl = (w.nzl != 0) ? 2'b10 : 2'b00;
                edr = (w.nzr != 0) ? 2'b10 : 2'b00;
                for (int i = w.first; i <= w.last; i++) begin
                    if (hist[i][0] === 1'b1) hl++;
                    if (hist[i][1] === 1'b1) hr++;
                    if (hist[i][3:2] !== edl || hist[i][5:4] !== edr) dbad++;
                end
                check("left_high_time", hl, w.hl, w.first);
                check("right_high_time", hr, w.hr, w.first);
                check("dir_bad_cycles", dbad, 0, w.first);
                check("moving", int'(hist[w.first][6] === 1'b1), int'(w.nzl != 0 || w.nzr != 0), w.first);
            end
        end
    end

    initial begin
        bit         sm;
        logic [1:0] st;
        int         len;
        @(negedge clk);
        repeat (4)   cyc(1'b1, 1'b0, 2'(($urandom)));
        repeat (300) cyc(1'b0, 1'b0, 2'(($urandom)));
        repeat (700) cyc(1'b0, 1'b1, 2'b11);
        repeat (700) cyc(1'b0, 1'b1, 2'b10);
        repeat (700) cyc(1'b0, 1'b1, 2'b01);
        repeat (700) cyc(1'b0, 1'b0, 2'b01);
        repeat (500) cyc(1'b0, 1'b1, 2'b11);
        cyc(1'b1, 1'b1, 2'b11);
        repeat (60)  cyc(1'b0, 1'b0, 2'b11);
        for (int s = 0; s < 25; s++) begin
            st  = 2'(($urandom));
            sm  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(20, 400);
            for (int k = 0; k < len; k++)
                cyc(($urandom_range(0, 1999) == 0), sm ^ ($urandom_range(0, 99) == 0), st);
        end
        if (mode != M_NONE) wclose(ecnt);
        for (int k = 0; k < 8 && q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drain", q.size(), 0, ecnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_pwm_drive.md
# motor_pwm_drive

Converts the 2-bit steering `state` from the line-tracker stage into PWM and H-bridge direction signals for the left and right wheel motors. It sits directly downstream of the tracker and directly upstream of the motor-driver pins. It uses slew-limited duty changes and glitch-free PWM updates. Gated by `start_move`, it ramps the car to a stop when that input is released.

## Interface
- `PWM_BITS`, 10: PWM counter width; period = 2^PWM_BITS clk cycles.
- `DUTY_FAST`, 10'd700: duty for the outer wheel or straight travel.
- `DUTY_SLOW`, 10'd250: duty for the inner wheel in a turn.
- `RAMP_DIV`, 4096: clk cycles between ramp steps.
- `RAMP_STEP`, 10'd16: maximum duty change per ramp step.

Ports:
- `clk` in 1: system clock. One clock domain; the reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `state` in 2: steering command. 2'b11 = straight, 2'b10 = turn left, 2'b01 = turn right, 2'b00 = stop.
- `start_move` in 1: level enable for motion.
- `left_pwm` out 1: left motor enable (PWM).
- `right_pwm` out 1: right motor enable (PWM).
- `left_dir` out 2: left H-bridge {IN1,IN2}. 2'b10 = forward, 2'b00 = coast.
- `right_dir` out 2: right H-bridge {IN3,IN4}, same encoding.
- `moving` out 1: high while either applied duty is non-zero.

## Operation
- Target duty pair (L,R) by `state`:
  - 11 → (FAST, FAST)
  - 10 → (SLOW, FAST)
  - 01 → (FAST, SLOW)
  - 00 → (0, 0)
- FSM states and transitions:
  - IDLE: counters held at 0, all outputs 0. Goes to RUN when `start_move`=1.
  - RUN: targets follow `state` every cycle. Goes to STOPPING when `start_move`=0.
  - STOPPING: targets forced to 0. Goes to RUN if `start_move` returns to 1. Goes to IDLE when both current duties reach 0.
- Ramp: a tick occurs every RAMP_DIV cycles. On each tick, every current duty moves toward its target by min(RAMP_STEP, |target−current|). It never overshoots and stays within 0..2^PWM_BITS−1.
- Applied duty latches current duty only when the PWM counter equals its maximum (end of period). A mid-period change is never visible.
- PWM: `x_pwm` = (pwm_cnt < applied_x). Duty 0 gives constant 0. Duty ≥ 2^PWM_BITS−1 gives high for all but one count.
- Direction: `x_dir` = 2'b10 when applied_x ≠ 0, otherwise 2'b00.

## Timing
- Reset values: FSM=IDLE; pwm_cnt, ramp_cnt, current and applied duties = 0; all outputs 0.
- Inputs are registered once: a `state` change reaches the target register 1 cycle later.
- `x_pwm` and `x_dir` are registered outputs.
- PWM counter free-runs in RUN and STOPPING, wrapping from 2^PWM_BITS−1 to 0.
- Ramp counter runs in RUN and STOPPING and resets to 0 on entering IDLE.
- Worst-case full-scale response: ceil(DUTY_FAST/RAMP_STEP)·RAMP_DIV cycles, plus up to 2^PWM_BITS cycles of latch delay.
- Simultaneous ramp tick and period end in the same cycle: the ramp update is applied first, and the latch captures the value before the update. The updated value appears in the next period.
- `reset` mid-operation forces the reset values on the next edge. Nothing decays.
- `start_move` toggling inside one cycle window: the FSM samples it only at clock edges. There is no debounce.

## Configuration
- `MOTOR_RAMP_EN` defined: slew limiting as described above.
- `MOTOR_RAMP_EN` undefined:
  - Current duty equals target directly; the ramp counter and ramp logic are removed.
  - STOPPING exits to IDLE at the next period end.
  - The glitch-free period-end latch is still applied.

## Structure
- Shared package `motor_pkg`:
  - steering encodings ST_STOP/ST_RIGHT/ST_LEFT/ST_STRAIGHT (matching the tracker's 2-bit encoding);
  - DIR_FWD/DIR_COAST constants;
  - the FSM state typedef.
- Sub-module `pwm_channel`, instantiated twice:
  - contains the duty ramp, period-end latch and comparator for one wheel;
  - takes the shared pwm_cnt, ramp tick and target as inputs.
- The top level owns the FSM, the counters and the target mapping.

## Test plan
- Reset, then `start_move`=0 for 5000 cycles → all outputs 0 and `moving`=0.
- `start_move`=1, `state`=11, default parameters → duties rise 16 per 4096 cycles and reach 700 after 44 ticks. Measured high time then equals 700 of every 1024 cycles on both wheels; `left_dir`=`right_dir`=2'b10.
- Steady 11, then `state`=10 → left ramps down to 250 and right stays at 700. No PWM period on either wheel shows a high time different from its latched duty.
- Steady 01, then `start_move`=0 → FSM goes to STOPPING, and both duties ramp to 0 (left from 700, right from 250). IDLE is reached once the left duty hits 0; `moving` falls and `x_dir`=2'b00.
- `reset` asserted while both duties are at 700 → outputs are 0 on the next edge, and the FSM is in IDLE.
- Build without `MOTOR_RAMP_EN`, step `state` 00→11 → duty 700 appears at the first period end after the target update, and no ramp steps occur.
